// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: per-channel synchronizer, stability counter,
// debounced level, registered rise/fall strobes and a registered "any held" flag.
module multi_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 20000,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_active
);

  localparam int             CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]  TERM     = CW'(STABLE_CYCLES - 1);
  // Idle level of an active-low input is 1, so the chain resets to "not pressed".
  localparam logic [WIDTH-1:0] SYNC_RST = ACTIVE_LOW ? '1 : '0;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  accept;

  // NOTE: every flop here uses <= so all stages sample pre-edge values; a blocking
  // assignment would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{SYNC_RST}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign s = sync_q[SYNC_STAGES-1] ^ {WIDTH{ACTIVE_LOW}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt_q;

    assign accept[i] = (s[i] != sig_out[i]) && (cnt_q == TERM);

    // Any agreement (bounce back) or an acceptance restarts the count, so the
    // terminal value is always consumed and the counter never wraps.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                   cnt_q <= '0;
      else if (s[i] == sig_out[i]) cnt_q <= '0;
      else if (cnt_q == TERM)      cnt_q <= '0;
      else                         cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_out    <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_active <= 1'b0;
    end else begin
      sig_out    <= sig_out ^ accept;
      rise_pulse <= accept & s;
      fall_pulse <= accept & ~s;
      any_active <= |sig_out;
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer (WIDTH=4, STABLE_CYCLES=20, SYNC_STAGES=2),
// with a second ACTIVE_LOW=1 instance for the inverted-input case.
module tb_multi_debouncer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, reset_al;
  logic [W-1:0] sig_in, sig_in_al;
  logic [W-1:0] sig_out, rise_pulse, fall_pulse;
  logic [W-1:0] sig_out_al, rise_pulse_al, fall_pulse_al;
  logic         any_active, any_active_al;

  always #5 clk = ~clk;

  multi_debouncer #(.WIDTH(W), .STABLE_CYCLES(20), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .sig_out(sig_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_active(any_active));

  multi_debouncer #(.WIDTH(W), .STABLE_CYCLES(20), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset_al), .sig_in(sig_in_al), .sig_out(sig_out_al),
    .rise_pulse(rise_pulse_al), .fall_pulse(fall_pulse_al), .any_active(any_active_al));

  int n_cmp  = 0;
  int n_fail = 0;

  // Pulse bookkeeping, accumulated once per clock in tick().
  int           rise_cnt [W];
  int           fall_cnt [W];
  int           rise_events, fall_events, both_events, al_pulse_events;
  logic [W-1:0] out_or;

  typedef struct {
    logic [W-1:0] in;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
  } walk_vec_t;

  walk_vec_t walk [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    foreach (rise_cnt[i]) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    rise_events = 0;
    fall_events = 0;
    both_events = 0;
    out_or      = '0;
  endtask

  // One clock: wait for the rising edge, then sample outputs 1 time unit later.
  // Stimulus changes also happen at this point, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] += int'(rise_pulse[i]);
      fall_cnt[i] += int'(fall_pulse[i]);
    end
    if (rise_pulse != '0) rise_events++;
    if (fall_pulse != '0) fall_events++;
    if ((rise_pulse & fall_pulse) != '0) both_events++;
    if ((rise_pulse_al | fall_pulse_al) != '0) al_pulse_events++;
    out_or |= sig_out;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    walk[0] = '{in: 4'b0010, exp_out: 4'b0010, exp_rise: 4'b0010, exp_fall: 4'b0001};
    walk[1] = '{in: 4'b0100, exp_out: 4'b0100, exp_rise: 4'b0100, exp_fall: 4'b0010};
    walk[2] = '{in: 4'b1000, exp_out: 4'b1000, exp_rise: 4'b1000, exp_fall: 4'b0100};
    walk[3] = '{in: 4'b0000, exp_out: 4'b0000, exp_rise: 4'b0000, exp_fall: 4'b1000};
    al_pulse_events = 0;
    clear_counts();

    // Reset is asynchronous: outputs must be 0 before any clock edge has occurred.
    reset     = 1'b1;
    reset_al  = 1'b1;
    sig_in    = 4'b0000;
    sig_in_al = 4'b1111;
    #2;
    check("reset_sig_out",    32'(sig_out), 32'h0);
    check("reset_pulses",     32'({rise_pulse, fall_pulse}), 32'h0);
    check("reset_any_active", 32'(any_active), 32'h0);
    check("reset_al_outputs", 32'({sig_out_al, rise_pulse_al, fall_pulse_al, any_active_al}), 32'h0);
    ticks(2);

    // Clean step to 0001 at reset release. Counting the edge that first samples the
    // new level as edge 1, sig_out changes on edge 22.
    reset    = 1'b0;
    reset_al = 1'b0;
    sig_in   = 4'b0001;
    ticks(21);
    check("step_before_latency", 32'(sig_out), 32'h0);
    tick();
    check("step_sig_out",     32'(sig_out), 32'h1);
    check("step_rise",        32'(rise_pulse), 32'h1);
    check("step_fall",        32'(fall_pulse), 32'h0);
    check("step_any_lag",     32'(any_active), 32'h0);
    tick();
    check("step_rise_1cycle", 32'(rise_pulse), 32'h0);
    check("step_any_active",  32'(any_active), 32'h1);

    // Walking one: old channel falls and new channel rises on the same edge.
    for (int v = 0; v < 4; v++) begin
      logic [W-1:0] prev;
      prev = (v == 0) ? 4'b0001 : walk[v-1].exp_out;
      clear_counts();
      sig_in = walk[v].in;
      ticks(21);
      check($sformatf("walk%0d_hold_old", v), 32'(sig_out), 32'(prev));
      tick();
      check($sformatf("walk%0d_pulses", v), 32'({rise_pulse, fall_pulse}),
            32'({walk[v].exp_rise, walk[v].exp_fall}));
      ticks(18);
      check($sformatf("walk%0d_sig_out", v), 32'(sig_out), 32'(walk[v].exp_out));
      check($sformatf("walk%0d_pulse_count", v), 32'({8'(rise_events), 8'(fall_events)}),
            32'({8'($countones(walk[v].exp_rise)), 8'($countones(walk[v].exp_fall))}));
    end

    // Glitch of 19 cycles on ch2 never reaches sig_out.
    clear_counts();
    sig_in = 4'b0100;
    ticks(19);
    sig_in = 4'b0000;
    ticks(40);
    check("glitch19_sig_out", 32'(out_or), 32'h0);
    check("glitch19_pulses",  32'(rise_events + fall_events), 32'h0);

    // 20 cycles is just enough to be accepted; the return to 0 is accepted later.
    clear_counts();
    sig_in = 4'b0100;
    ticks(20);
    sig_in = 4'b0000;
    ticks(2);
    check("pulse20_accepted", 32'(sig_out), 32'h4);
    ticks(40);
    check("pulse20_counts", 32'({8'(rise_cnt[2]), 8'(fall_cnt[2])}), 32'h0101);
    check("pulse20_no_both", 32'(both_events), 32'h0);

    // Bounce on ch1: 5 high / 5 low for 100 cycles, then held high.
    clear_counts();
    for (int p = 0; p < 10; p++) begin
      sig_in = 4'b0010;
      ticks(5);
      sig_in = 4'b0000;
      ticks(5);
    end
    check("bounce_no_change", 32'(out_or), 32'h0);
    sig_in = 4'b0010;
    ticks(21);
    check("bounce_before_latency", 32'(sig_out), 32'h0);
    tick();
    check("bounce_sig_out", 32'(sig_out), 32'h2);
    ticks(10);
    check("bounce_one_rise", 32'(rise_cnt[1]), 32'd1);

    // Reset at count 10 while ch3 goes high and ch0 is already accepted.
    sig_in = 4'b0001;
    ticks(30);
    check("pre_reset_sig_out", 32'(sig_out), 32'h1);
    clear_counts();
    sig_in = 4'b1001;
    ticks(12);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_outputs", 32'({sig_out, rise_pulse, fall_pulse, 3'b000, any_active}), 32'h0);
    ticks(2);
    check("midreset_held", 32'({sig_out, any_active}), 32'h0);
    reset = 1'b0;
    ticks(21);
    check("postreset_before_latency", 32'(sig_out), 32'h0);
    tick();
    check("postreset_sig_out", 32'(sig_out), 32'h9);
    check("postreset_rise",    32'(rise_pulse), 32'h9);
    ticks(5);
    check("postreset_no_fall", 32'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'd0);

    // Active-low instance: idle 1111 never read as pressed, then ch0 pressed.
    check("al_idle_sig_out", 32'(sig_out_al), 32'h0);
    check("al_idle_no_pulse", 32'(al_pulse_events), 32'd0);
    sig_in_al = 4'b1110;
    ticks(21);
    check("al_before_latency", 32'(sig_out_al), 32'h0);
    tick();
    check("al_sig_out", 32'(sig_out_al), 32'h1);
    check("al_rise",    32'({rise_pulse_al, fall_pulse_al}), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
